param_sync_fifo: RTL

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo.sv | 115 +++++++++++
 1 files changed

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with level flags, sticky error flags and a registered or first-word-fall-through read port.
// Read latency: 1 edge (FWFT=0) or 0 (FWFT=1). A write at full is accepted only alongside an accepted read; otherwise it is dropped and flagged.
module param_sync_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        d_in,
  input  logic                     w_en,
  input  logic                     r_en,
  input  logic                     err_clr,
  output logic [DATA_W-1:0]        d_out,
  output logic                     f_full_flag,
  output logic                     f_half_full_flag,
  output logic                     f_empty_flag,
  output logic                     f_almost_full_flag,
  output logic                     f_almost_empty_flag,
  output logic [$clog2(DEPTH):0]   f_count,
  output logic                     f_overflow,
  output logic                     f_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] HALF_C  = CW'(DEPTH / 2);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              rd_acc;
  logic              wr_acc;
  logic              wr_drop;
  logic              rd_rej;
  logic              ovf_q;
  logic              unf_q;

  // A read at empty is never accepted, so a same-edge write into an empty FIFO cannot be bypassed.
  always_comb begin
    rd_acc  = r_en && (count != '0);
    wr_acc  = w_en && ((count != DEPTH_C) || rd_acc);
    wr_drop = w_en && !wr_acc;
    rd_rej  = r_en && (count == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem[wr_ptr] <= d_in;
  end

  // A fresh error on the clearing edge wins over err_clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_drop)      ovf_q <= 1'b1;
      else if (err_clr) ovf_q <= 1'b0;
      if (rd_rej)       unf_q <= 1'b1;
      else if (err_clr) unf_q <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATA_W-1:0] dout_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)       dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rd_ptr];
      end
      assign d_out = dout_q;
    end else begin : g_fwft_read
      // last_q remembers the most recently popped word so d_out holds while empty.
      logic [DATA_W-1:0] last_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)       last_q <= '0;
        else if (rd_acc) last_q <= mem[rd_ptr];
      end
      assign d_out = (count != '0) ? mem[rd_ptr] : last_q;
    end
  endgenerate

  assign f_count             = count;
  assign f_full_flag         = (count == DEPTH_C);
  assign f_half_full_flag    = (count >= HALF_C);
  assign f_empty_flag        = (count == '0);
  assign f_almost_full_flag  = (count >= AF_C);
  assign f_almost_empty_flag = (count <= AE_C);
  assign f_overflow          = ovf_q;
  assign f_underflow         = unf_q;

endmodule
